multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control unit that sequences the multi-cycle ARM datapath, which shares one unified instruction/data memory.
- Main FSM walks every instruction through fetch, decode, execute, memory and writeback cycles.
- Decodes ALU operation and immediate/register-source selects; holds the NZCV flags and evaluates the condition field.
- Drives all datapath mux selects and write enables (IR, PC, register file, memory) from Instr and ALUFlags.

Parameters:
FLAGS_RESET, 4'b0000, reset value of the NZCV flag register {N,Z,C,V}

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
Instr  input  32  IR contents; uses Cond=[31:28], Op=[27:26], Funct=[25:20], Rd=[15:12]
ALUFlags  input  4  {N,Z,C,V} from the ALU, current cycle
PCWrite  output  1  PC register enable
MemWrite  output  1  memory write enable
RegWrite  output  1  register file write enable
IRWrite  output  1  instruction register enable
AdrSrc  output  1  memory address: 0=PC, 1=Result
ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  output  1  0=RD1 register, 1=PC
ALUSrcB  output  2  00=RD2 register, 01=ExtImm, 10=constant 4
ImmSrc  output  2  equals Op
RegSrc  output  2  [0]=(Op==10), [1]=(Op==01)
ALUControl  output  2  00=ADD, 01=SUB, 10=AND, 11=ORR
State  output  4  current FSM state, for debug

Behaviour:
- FSM states (encoding): FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9. Codes 10-15 go to FETCH.
- Transitions:
  - FETCH->DECODE.
  - DECODE: Op=01->MEMADR; Op=00 and Funct[5]=0->EXECUTER; Op=00 and Funct[5]=1->EXECUTEI; Op=10->BRANCH; Op=11->FETCH (no-op).
  - MEMADR: Funct[0]=1->MEMREAD, else MEMWRITE.
  - MEMREAD->MEMWB->FETCH. MEMWRITE->FETCH. EXECUTER/EXECUTEI->ALUWB->FETCH. BRANCH->FETCH.
- Moore controls. Unlisted signals are 0; ALUOp is internal.
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1.
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode:
  - ALUOp=0 gives ALUControl=00 and FlagW=00.
  - ALUOp=1 decodes Funct[4:1]: 0100->00, 0010->01, 0000->10, 1100->11, anything else->00.
  - FlagW[1]=Funct[0]. FlagW[0]=Funct[0] and ALUControl in {00,01}. Unknown Funct[4:1] forces FlagW=00.
- Condition evaluation, from Cond and the flag register:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL=1; 1111=0.
- CondEx register:
  - Captured at the DECODE->next edge.
  - Held until the next DECODE.
  - Cleared to 0 on reset.
- Flag register:
  - Updates only on edges leaving EXECUTER/EXECUTEI, and only when CondEx=1.
  - FlagW[1] loads N,Z from ALUFlags; FlagW[0] loads C,V.
- Write enables:
  - PCS = (Rd==15 and RegW) or Branch.
  - PCWrite = NextPC or (PCS and CondEx).
  - RegWrite = RegW and CondEx and not (Rd==15).
  - MemWrite = MemW and CondEx.
  - IRWrite comes from FETCH only.
- Latency in cycles: data-processing 4; LDR 5; STR 4; branch 3; Op=11 2.
- Reset (reset=0):
  - Immediately (async): State=FETCH, flags=FLAGS_RESET, CondEx=0.
  - While reset=0: PCWrite, MemWrite, RegWrite and IRWrite are forced to 0; mux selects show FETCH values.
  - Reset asserted mid-instruction aborts it, with no write-enable glitch.
  - First FETCH occurs in the first full cycle after release.

Test Plan:
- ADD R1,R2,R3 (0xE0821003) -> State 0,1,6,8,0; ALUControl=00 in state 6; RegWrite=1 only in state 8; PCWrite=1 only in state 0.
- LDR R1,[R2,#4] (0xE5921004) -> State 0,1,2,3,4,0; AdrSrc=1 in state 3; ResultSrc=01 and RegWrite=1 in state 4.
- STR R1,[R2,#4] (0xE5821004) -> State 0,1,2,5,0; MemWrite=1 and AdrSrc=1 in state 5 only; RegWrite never 1.
- SUBS R0,R0,R0 (0xE0500000) with ALUFlags=0100 in state 6 -> Z=1 latched. Then:
  - BEQ (0x0A000001) -> PCWrite=1 in BRANCH.
  - BNE (0x1A000001) -> PCWrite=0 in BRANCH.
- ADD PC,R2,R3 (0xE082F003) -> PCWrite=1 and RegWrite=0 in ALUWB.
- Assert reset during MEMWRITE -> MemWrite=0 in the same cycle; State=0; flags=0000; after release the next instruction fetches normally.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control unit for the multi-cycle ARM datapath with a unified instruction/data memory.
// Sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, decodes
// the ALU operation, holds the NZCV flags and gates all write enables by the condition.
// Ports:
//   clk, reset (async, active-low)
//   Instr      : IR contents (Cond, Op, Funct, Rd fields used)
//   ALUFlags   : {N,Z,C,V} produced by the ALU this cycle
//   PCWrite, MemWrite, RegWrite, IRWrite : write enables (forced low during reset)
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl : datapath selects
//   State      : current FSM state for debug
module multicycle_controller #(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t      state, state_next;
  logic [3:0]  cond, rd;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  flags;
  logic        condex, cond_ok;
  logic        next_pc, branch, reg_w, mem_w, ir_write, alu_op;
  logic [1:0]  flag_w;
  logic        pcs;
  logic        unused_instr;

  assign cond  = Instr[31:28];
  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign rd    = Instr[15:12];
  assign unused_instr = ^{Instr[19:16], Instr[11:0]};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_next;
  end

  // Next-state and Moore control decode
  always_comb begin
    state_next = FETCH;
    next_pc    = 1'b0;
    branch     = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    ir_write   = 1'b0;
    alu_op     = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    case (state)
      FETCH: begin
        state_next = DECODE;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        ir_write   = 1'b1;
        next_pc    = 1'b1;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (op)
          2'b01:   state_next = MEMADR;
          2'b00:   state_next = funct[5] ? EXECUTEI : EXECUTER;
          2'b10:   state_next = BRANCH;
          default: state_next = FETCH;
        endcase
      end
      MEMADR: begin
        state_next = funct[0] ? MEMREAD : MEMWRITE;
        ALUSrcB    = 2'b01;
      end
      MEMREAD: begin
        state_next = MEMWB;
        AdrSrc     = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      EXECUTER: begin
        state_next = ALUWB;
        alu_op     = 1'b1;
      end
      EXECUTEI: begin
        state_next = ALUWB;
        ALUSrcB    = 2'b01;
        alu_op     = 1'b1;
      end
      ALUWB: begin
        reg_w = 1'b1;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: state_next = FETCH;
    endcase
  end

  // ALU decode; logical ops only write N,Z
  always_comb begin
    ALUControl = 2'b00;
    flag_w     = 2'b00;
    if (alu_op) begin
      case (funct[4:1])
        4'b0100: begin ALUControl = 2'b00; flag_w = {funct[0], funct[0]}; end
        4'b0010: begin ALUControl = 2'b01; flag_w = {funct[0], funct[0]}; end
        4'b0000: begin ALUControl = 2'b10; flag_w = {funct[0], 1'b0};     end
        4'b1100: begin ALUControl = 2'b11; flag_w = {funct[0], 1'b0};     end
        default: begin ALUControl = 2'b00; flag_w = 2'b00;                end
      endcase
    end
  end

  // Condition check against the stored flags {N,Z,C,V}
  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'b0000: cond_ok = flags[2];
      4'b0001: cond_ok = ~flags[2];
      4'b0010: cond_ok = flags[1];
      4'b0011: cond_ok = ~flags[1];
      4'b0100: cond_ok = flags[3];
      4'b0101: cond_ok = ~flags[3];
      4'b0110: cond_ok = flags[0];
      4'b0111: cond_ok = ~flags[0];
      4'b1000: cond_ok = flags[1] & ~flags[2];
      4'b1001: cond_ok = ~flags[1] | flags[2];
      4'b1010: cond_ok = (flags[3] == flags[0]);
      4'b1011: cond_ok = (flags[3] != flags[0]);
      4'b1100: cond_ok = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: cond_ok = flags[2] | (flags[3] != flags[0]);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // CondEx sampled once per instruction, at the end of DECODE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              condex <= 1'b0;
    else if (state == DECODE) condex <= cond_ok;
  end

  // Flags written only when an executed instruction leaves its EXECUTE state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags <= FLAGS_RESET;
    end else if (((state == EXECUTER) || (state == EXECUTEI)) && condex) begin
      if (flag_w[1]) flags[3:2] <= ALUFlags[3:2];
      if (flag_w[0]) flags[1:0] <= ALUFlags[1:0];
    end
  end

  // Write enables, held low for as long as reset is asserted
  assign pcs      = ((rd == 4'hF) && reg_w) || branch;
  assign PCWrite  = reset & (next_pc | (pcs & condex));
  assign RegWrite = reset & reg_w & condex & (rd != 4'hF);
  assign MemWrite = reset & mem_w & condex;
  assign IRWrite  = reset & ir_write;

  assign ImmSrc = op;
  assign RegSrc = {(op == 2'b01), (op == 2'b10)};
  assign State  = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks instruction classes cycle by cycle,
// checking State and the {PCWrite,MemWrite,RegWrite,IRWrite} enables plus key selects.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
  logic [3:0]  State;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_controller #(.FLAGS_RESET(4'b0000)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .State(State)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check one cycle (sampled just after the falling edge), then move to the next one.
  // we = {PCWrite, MemWrite, RegWrite, IRWrite}
  task automatic cyc(input string tag, input logic [3:0] st, input logic [3:0] we);
    #1;
    check({tag, ".state"}, 32'(State), 32'(st));
    check({tag, ".we"}, 32'({PCWrite, MemWrite, RegWrite, IRWrite}), 32'(we));
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b0;
    Instr    = 32'h0;
    ALUFlags = 4'b0000;
    @(negedge clk);
    #1;
    check("rst.state", 32'(State), 32'd0);
    check("rst.we", 32'({PCWrite, MemWrite, RegWrite, IRWrite}), 32'd0);
    check("rst.sel", 32'({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}), 32'b0_1_10_10);
    @(negedge clk);

    // ADD R1,R2,R3
    reset = 1'b1;
    Instr = 32'hE0821003;
    cyc("add.f", 4'd0, 4'b1001);
    cyc("add.d", 4'd1, 4'b0000);
    check("add.aluctl", 32'(ALUControl), 32'd0);
    check("add.srcb", 32'(ALUSrcB), 32'd0);
    cyc("add.e", 4'd6, 4'b0000);
    cyc("add.wb", 4'd8, 4'b0010);

    // LDR R1,[R2,#4]
    Instr = 32'hE5921004;
    cyc("ldr.f", 4'd0, 4'b1001);
    #1;
    check("ldr.imm", 32'({ImmSrc, RegSrc}), 32'b01_10);
    cyc("ldr.d", 4'd1, 4'b0000);
    check("ldr.adrsel", 32'({ALUSrcA, ALUSrcB}), 32'b0_01);
    cyc("ldr.a", 4'd2, 4'b0000);
    check("ldr.adr", 32'(AdrSrc), 32'd1);
    cyc("ldr.r", 4'd3, 4'b0000);
    check("ldr.res", 32'(ResultSrc), 32'd1);
    cyc("ldr.wb", 4'd4, 4'b0010);

    // STR R1,[R2,#4]
    Instr = 32'hE5821004;
    cyc("str.f", 4'd0, 4'b1001);
    cyc("str.d", 4'd1, 4'b0000);
    cyc("str.a", 4'd2, 4'b0000);
    check("str.adr", 32'(AdrSrc), 32'd1);
    cyc("str.w", 4'd5, 4'b0100);

    // SUBS R0,R0,R0 with Z from the ALU
    Instr = 32'hE0500000;
    cyc("subs.f", 4'd0, 4'b1001);
    cyc("subs.d", 4'd1, 4'b0000);
    ALUFlags = 4'b0100;
    check("subs.aluctl", 32'(ALUControl), 32'd1);
    cyc("subs.e", 4'd6, 4'b0000);
    ALUFlags = 4'b0000;
    cyc("subs.wb", 4'd8, 4'b0010);

    // BEQ taken (Z=1)
    Instr = 32'h0A000001;
    cyc("beq.f", 4'd0, 4'b1001);
    #1;
    check("beq.regsrc", 32'({ImmSrc, RegSrc}), 32'b10_01);
    cyc("beq.d", 4'd1, 4'b0000);
    check("beq.srcb", 32'({ALUSrcA, ALUSrcB, ResultSrc}), 32'b0_01_10);
    cyc("beq.b", 4'd9, 4'b1000);

    // BNE not taken
    Instr = 32'h1A000001;
    cyc("bne.f", 4'd0, 4'b1001);
    cyc("bne.d", 4'd1, 4'b0000);
    cyc("bne.b", 4'd9, 4'b0000);

    // SUBSNE skipped: nothing written, flags keep Z=1
    Instr = 32'h10500000;
    cyc("subsne.f", 4'd0, 4'b1001);
    cyc("subsne.d", 4'd1, 4'b0000);
    cyc("subsne.e", 4'd6, 4'b0000);
    cyc("subsne.wb", 4'd8, 4'b0000);

    // BEQ still taken
    Instr = 32'h0A000001;
    cyc("beq2.f", 4'd0, 4'b1001);
    cyc("beq2.d", 4'd1, 4'b0000);
    cyc("beq2.b", 4'd9, 4'b1000);

    // ADD PC,R2,R3: PC written, register file not
    Instr = 32'hE082F003;
    cyc("addpc.f", 4'd0, 4'b1001);
    cyc("addpc.d", 4'd1, 4'b0000);
    cyc("addpc.e", 4'd6, 4'b0000);
    cyc("addpc.wb", 4'd8, 4'b1000);

    // Op=11 falls straight back to FETCH
    Instr = 32'hEC000000;
    cyc("nop.f", 4'd0, 4'b1001);
    cyc("nop.d", 4'd1, 4'b0000);

    // STR aborted by reset during MEMWRITE
    Instr = 32'hE5821004;
    cyc("rstr.f", 4'd0, 4'b1001);
    cyc("rstr.d", 4'd1, 4'b0000);
    cyc("rstr.a", 4'd2, 4'b0000);
    #1;
    check("rstr.state5", 32'(State), 32'd5);
    check("rstr.memw1", 32'(MemWrite), 32'd1);
    reset = 1'b0;
    #1;
    check("rstr.memw0", 32'(MemWrite), 32'd0);
    check("rstr.state0", 32'(State), 32'd0);
    check("rstr.we", 32'({PCWrite, MemWrite, RegWrite, IRWrite}), 32'd0);
    check("rstr.sel", 32'({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}), 32'b0_1_10_10);
    @(negedge clk);

    // Flags cleared by reset: BEQ not taken, BNE taken
    reset = 1'b1;
    Instr = 32'h0A000001;
    cyc("pbeq.f", 4'd0, 4'b1001);
    cyc("pbeq.d", 4'd1, 4'b0000);
    cyc("pbeq.b", 4'd9, 4'b0000);
    Instr = 32'h1A000001;
    cyc("pbne.f", 4'd0, 4'b1001);
    cyc("pbne.d", 4'd1, 4'b0000);
    cyc("pbne.b", 4'd9, 4'b1000);
    #1;
    check("end.state", 32'(State), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
